pic_priority_sequencer: RTL

Interrupt sequencer for the 8-level PIC. It resolves priority among pending IRR bits against the in-service register (ISR) and raises INT to the CPU. It runs the two-pulse INTA acknowledge, sets the ISR bit and requests clearing of the matching IRR bit. It also supplies the vector byte and retires ISR bits on EOI or automatic EOI.

---
 rtl/pic_priority_sequencer_pkg.sv | 29 ++
 rtl/pic_priority_sequencer_if.sv | 34 +++
 rtl/pic_priority_sequencer_resolver.sv | 28 ++
 rtl/pic_priority_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pic_priority_sequencer_pkg.sv
// Shared types and helpers for the PIC priority sequencer: FSM states,
// level width and rotate-relative priority arithmetic.
package pic_pkg;

  localparam int NUM_LEVELS = 8;

  typedef logic [2:0] level_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_ACK1,
    ST_WAIT2,
    ST_ACK2
  } state_t;

  // Rank 0 is the highest priority: the level just after lowest_ptr.
  function automatic level_t prio_rank(level_t level, level_t ptr);
    return level - ptr - 3'd1;
  endfunction

  function automatic logic [NUM_LEVELS-1:0] level_onehot(level_t level);
    logic [NUM_LEVELS-1:0] oh;
    oh        = '0;
    oh[level] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pic_priority_sequencer_if.sv
// Bus between the IRR/command logic (master) and the priority sequencer
// (slave), including the CPU-side INT/INTA/vector signals.
interface pic_priority_sequencer_if;
  import pic_pkg::*;

  logic [NUM_LEVELS-1:0] irr;
  logic                  inta_n;
  logic [4:0]            vector_base;
  logic                  aeoi_en;
  logic                  rotate_en;
  logic                  eoi_valid;
  logic                  eoi_specific;
  level_t                eoi_level;

  logic                  int_out;
  logic [NUM_LEVELS-1:0] isr;
  logic [NUM_LEVELS-1:0] clr_irr;
  logic [7:0]            vector;
  logic                  vector_valid;
  level_t                lowest_ptr;

  modport master (
    output irr, inta_n, vector_base, aeoi_en, rotate_en,
           eoi_valid, eoi_specific, eoi_level,
    input  int_out, isr, clr_irr, vector, vector_valid, lowest_ptr
  );

  modport slave (
    input  irr, inta_n, vector_base, aeoi_en, rotate_en,
           eoi_valid, eoi_specific, eoi_level,
    output int_out, isr, clr_irr, vector, vector_valid, lowest_ptr
  );

endinterface

// File: rtl/pic_priority_sequencer_resolver.sv
// Combinational priority resolver: returns the highest-priority set bit of
// a mask, where priority starts just above lowest_ptr and wraps around.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] mask,
  input  level_t                lowest_ptr,
  output logic                  found,
  output level_t                level
);

  level_t cand;

  // Scan from lowest to highest priority so the highest set bit wins last.
  always_comb begin
    found = 1'b0;
    level = lowest_ptr;
    cand  = '0;
    for (int k = NUM_LEVELS - 1; k >= 0; k--) begin
      cand = lowest_ptr + 3'd1 + level_t'(k);
      if (mask[cand]) begin
        found = 1'b1;
        level = cand;
      end
    end
  end

endmodule

// File: rtl/pic_priority_sequencer.sv
// 8-level PIC interrupt sequencer: priority resolution against the ISR,
// two-pulse INTA handshake, vector output and EOI/AEOI retirement.
module pic_priority_sequencer
  import pic_pkg::*;
#(
  parameter level_t SPURIOUS_LEVEL   = 3'd7,
  parameter level_t ROTATE_RESET_PTR = 3'd7
) (
  input  logic                     clk,
  input  logic                     reset,
  pic_priority_sequencer_if.slave  bus
);

  state_t                state_q, state_d;
  level_t                level_q, level_d;
  logic                  spurious_q, spurious_d;
  logic                  prev_inta_q;
  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [NUM_LEVELS-1:0] clr_irr_q, clr_irr_d;
  logic [7:0]            vector_q, vector_d;
  logic                  vector_valid_q, vector_valid_d;
  level_t                lowest_ptr_q, lowest_ptr_d;

  level_t                eff_ptr;
  logic                  irr_found, isr_found;
  level_t                irr_level, isr_level;
  logic                  req_valid;
  logic                  inta_fall, inta_rise;

  logic [NUM_LEVELS-1:0] isr_clr, isr_set;
  logic                  eoi_rot, aeoi_rot;
  level_t                eoi_rot_level;

  // Fixed mode behaves as if IR7 were the lowest-priority level.
  assign eff_ptr = bus.rotate_en ? lowest_ptr_q : 3'd7;

  pic_priority_resolver u_irr_res (
    .mask       (bus.irr),
    .lowest_ptr (eff_ptr),
    .found      (irr_found),
    .level      (irr_level)
  );

  pic_priority_resolver u_isr_res (
    .mask       (isr_q),
    .lowest_ptr (eff_ptr),
    .found      (isr_found),
    .level      (isr_level)
  );

  assign req_valid = irr_found &&
                     (!isr_found ||
                      (prio_rank(irr_level, eff_ptr) < prio_rank(isr_level, eff_ptr)));

  assign inta_fall = prev_inta_q & ~bus.inta_n;
  assign inta_rise = ~prev_inta_q & bus.inta_n;

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    spurious_d     = spurious_q;
    vector_d       = vector_q;
    vector_valid_d = vector_valid_q;
    clr_irr_d      = '0;
    lowest_ptr_d   = lowest_ptr_q;
    isr_clr        = '0;
    isr_set        = '0;
    eoi_rot        = 1'b0;
    eoi_rot_level  = '0;
    aeoi_rot       = 1'b0;

    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        isr_clr       = level_onehot(bus.eoi_level);
        eoi_rot       = bus.rotate_en;
        eoi_rot_level = bus.eoi_level;
      end else if (isr_found) begin
        isr_clr       = level_onehot(isr_level);
        eoi_rot       = bus.rotate_en;
        eoi_rot_level = isr_level;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (inta_fall) begin
          if (req_valid) begin
            level_d    = irr_level;
            spurious_d = 1'b0;
            isr_set    = level_onehot(irr_level);
            clr_irr_d  = level_onehot(irr_level);
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
          state_d = ST_ACK1;
        end else if (!req_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (inta_fall) begin
          vector_d       = {bus.vector_base, level_q};
          vector_valid_d = 1'b1;
          state_d        = ST_ACK2;
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          vector_valid_d = 1'b0;
          state_d        = ST_IDLE;
          if (bus.aeoi_en && !spurious_q) begin
            isr_clr  = isr_clr | level_onehot(level_q);
            aeoi_rot = bus.rotate_en;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clears land before the set, so a same-cycle set of that bit survives.
    isr_d = (isr_q & ~isr_clr) | isr_set;

    if (eoi_rot)       lowest_ptr_d = eoi_rot_level;
    else if (aeoi_rot) lowest_ptr_d = level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      level_q        <= '0;
      spurious_q     <= 1'b0;
      prev_inta_q    <= 1'b1;
      isr_q          <= '0;
      clr_irr_q      <= '0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
      lowest_ptr_q   <= ROTATE_RESET_PTR;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      spurious_q     <= spurious_d;
      prev_inta_q    <= bus.inta_n;
      isr_q          <= isr_d;
      clr_irr_q      <= clr_irr_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      lowest_ptr_q   <= lowest_ptr_d;
    end
  end

  assign bus.int_out      = (state_q == ST_PEND);
  assign bus.isr          = isr_q;
  assign bus.clr_irr      = clr_irr_q;
  assign bus.vector       = vector_q;
  assign bus.vector_valid = vector_valid_q;
  assign bus.lowest_ptr   = lowest_ptr_q;

endmodule
